// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic types and constants for the multiplier/divider pair
package arith_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divisor width, matching the multiplier's x operand width
  localparam int DIVW = 4;

  // Bits needed to count 0..n-1 (at least one bit)
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: trial subtract and restore
module div_step
  import arith_pkg::*;
(
  input  logic [DIVW:0]   p,
  input  logic [DIVW-1:0] divisor,
  output logic [DIVW:0]   p_next,
  output logic            q_bit
);

  // p - divisor is formed as p + ~{0,divisor} + 1; a carry out of the top
  // cell means no borrow, i.e. p >= divisor.
  logic [DIVW:0]   sub_b;
  logic [DIVW:0]   diff;
  logic [DIVW+1:0] carry;

  assign sub_b    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i <= DIVW; i++) begin : g_chain
      full_adder u_fa (
        .a  (p[i]),
        .b  (sub_b[i]),
        .ci (carry[i]),
        .s  (diff[i]),
        .co (carry[i+1])
      );
    end
  endgenerate

  assign q_bit  = carry[DIVW+1];
  assign p_next = q_bit ? diff : p;

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential N-by-4 restoring divider, one quotient bit per clock
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      dividend,
  input  logic [DIVW-1:0]   divisor,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      quotient,
  output logic [DIVW-1:0]   remainder,
  output logic              div_by_zero
);

  localparam int CW = clog2(N);

  state_t          state;
  logic [N-1:0]    dreg;     // dividend shifts out the top, quotient bits shift in the bottom
  logic [DIVW-1:0] dvs;
  logic [DIVW:0]   prem;     // 5-bit partial remainder; MSB stays 0 between steps
  logic [CW-1:0]   cnt;

  logic [DIVW:0]   p_shift;
  logic [DIVW:0]   p_next;
  logic            q_bit;
  logic            unused_prem_msb;

  // The partial remainder is always below the divisor, so its MSB is never shifted out
  assign p_shift         = {prem[DIVW-1:0], dreg[N-1]};
  assign unused_prem_msb = prem[DIVW];

  div_step u_step (
    .p       (p_shift),
    .divisor (dvs),
    .p_next  (p_next),
    .q_bit   (q_bit)
  );

  // Control FSM, datapath registers and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      dreg        <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dreg <= dividend;
            dvs  <= divisor;
            prem <= '0;
            cnt  <= CW'(N - 1);
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          dreg <= {dreg[N-2:0], q_bit};
          prem <= p_next;
          if (cnt == '0) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= {dreg[N-2:0], q_bit};
            remainder   <= p_next[DIVW-1:0];
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [3:0]   divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [3:0]   remainder;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] q;
    logic [3:0]   r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failures = 0;
  int   done_pulses = 0;
  int   lat = 0;
  int   p0 = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Count done pulses away from the active edge
  always @(negedge clk) begin
    if (done === 1'b1) done_pulses <= done_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue_exp(input logic [N-1:0] a, input logic [3:0] b,
                           input logic [N-1:0] eq, input logic [3:0] er, input logic edz);
    exp_t e;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [3:0] b);
    if (b == 4'd0) issue_exp(a, b, {N{1'b1}}, 4'd0, 1'b1);
    else           issue_exp(a, b, N'(a / b), 4'(a % b), 1'b0);
  endtask

  task automatic complete(input string tag, input int exp_lat);
    exp_t e;
    while (done !== 1'b1 && lat < 3 * N) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) begin
      check({tag, "_timeout"}, done, 1);
    end else if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_remainder"}, remainder, e.r);
      check({tag, "_div_by_zero"}, div_by_zero, e.dz);
      check({tag, "_busy_in_done"}, busy, 1);
      if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    end
    @(posedge clk); #1;
    check({tag, "_done_cleared"}, done, 0);
    check({tag, "_busy_cleared"}, busy, 0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed operations
    issue(8'd200, 4'd7);  complete("200_7", N + 1);
    issue(8'd255, 4'd15); complete("255_15", N + 1);
    issue(8'd5, 4'd9);    complete("5_9", N + 1);
    issue(8'd0, 4'd3);    complete("0_3", N + 1);

    // Divide by zero, then a valid op clears the flag
    issue(8'd77, 4'd0);   complete("div0", 1);
    issue(8'd100, 4'd10); complete("100_10", N + 1);

    // start while busy is ignored
    issue(8'd200, 4'd7);
    @(posedge clk); #1;
    lat++;
    dividend = 8'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    p0 = done_pulses;
    complete("ignored_start", N + 1);
    repeat (N + 4) @(posedge clk);
    #1;
    check("single_done_pulse", done_pulses - p0, 1);

    // Reset mid-operation aborts without a done pulse
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    p0 = done_pulses;
    repeat (N + 4) @(posedge clk);
    #1;
    check("abort_no_done", done_pulses - p0, 0);
    issue(8'd100, 4'd3); complete("100_3", N + 1);

    // Full sweep of dividends against every non-zero divisor
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(8'(a), 4'(b));
        complete("sweep", N + 1);
      end
    end

    // Multiply-then-divide: x*y divided by x must return y exactly
    for (int x = 1; x < 16; x++) begin
      for (int y = 0; y * x < 256; y++) begin
        issue_exp(8'(x * y), 4'(x), 8'(y), 4'd0, 1'b0);
        complete("muldiv", N + 1);
      end
    end

    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
